morse_encoder: RTL and testbench
================================

# morse_encoder

Morse transmitter: accepts one ASCII character per valid/ready handshake, looks up its dot/dash pattern and plays it out as timed marks and gaps on a 2-bit symbol line and a 1-bit key line. Sits upstream of the Morse decoder as the sending end of the same link: `morse_signal` uses the same coding (2'b01 dot, 2'b10 dash, 2'b00 silence). Element timing is derived from a programmable dot-unit length in clock cycles.

## Interface
- `UNIT_CYCLES`, default 4: clock cycles per Morse unit; legal range ≥1.
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `char_valid`  in  1  upstream has a character on `char_data`.
- `char_data`  in  8  ASCII character; sampled only on handshake.
- `char_ready`  out  1  encoder can accept a character.
- `morse_signal`  out  2  2'b01 dot mark, 2'b10 dash mark, 2'b00 gap/idle; 2'b11 never driven.
- `key`  out  1  tone on; equals OR of `morse_signal` bits, registered.
- `char_done`  out  1  one-cycle pulse on the final gap cycle of a character or space.
- `char_err`  out  1  one-cycle pulse for an unsupported character.

## Operation
- Handshake: transfer when `char_valid && char_ready` at a rising edge; `char_data` captured into an internal register then. `char_ready` is high only in IDLE.
- Lookup, on the captured byte: 3-bit length (1-5) and 5-bit pattern, MSB-first, 1 = dash. Lowercase 0x61-0x7A maps to uppercase. Supported: A-Z (standard ITU codes), 0x20 space, plus digits per Configuration. Everything else is unsupported.
- States:
  - IDLE: all outputs low except `char_ready`=1. On handshake: letter → MARK, space → WGAP, unsupported → ERR.
  - MARK: drive the current element for 1 unit (dot) or 3 units (dash). Then GAP if elements remain, else LGAP.
  - GAP: 1 unit of silence, then MARK with the next element.
  - LGAP: 3 units of silence; `char_done` on the last cycle; then IDLE.
  - WGAP: 4 units of silence, so a space after a letter's 3-unit gap totals 7 units; `char_done` on the last cycle; then IDLE.
  - ERR: one cycle with `char_err`=1, no marks; then IDLE.
- Datapath: element index counter 3 bits; unit cycle counter wide enough for 4*UNIT_CYCLES-1, counts down and reloads on each state entry.
- Reset: at any time, including mid-character, the next cycle is IDLE, the pattern is discarded, and all outputs are 0. `char_ready` is 0 while `rst` is high and 1 on the first cycle after release.

## Timing
- All outputs are registered.
- For a handshake at edge T with U = UNIT_CYCLES:
  - First element is driven in cycles T+1 .. T+U (dot) or T+1 .. T+3U (dash).
  - Each element is followed by U gap cycles. The last element is followed by 3U gap cycles.
  - `char_done` is high in the final gap cycle. `char_ready` rises the next cycle.
- Letter duration: (sum of element units + (n-1) intra-gaps + 3) × U cycles, then one cycle to IDLE. Back-to-back letters therefore have exactly a 3-unit gap.
- Space: 4U silent cycles after the handshake, `char_done` in the last of them.
- Unsupported character: `char_err` in cycle T+1, `char_ready` high at T+2.
- `char_valid` held high across `char_done`: the next character is accepted at the first IDLE edge; there is no bubble beyond that cycle.

## Configuration
- `MORSE_ENC_DIGITS_EN` defined: digits 0x30-0x39 are supported, with five-element ITU codes (e.g. '5' = ....., '0' = -----).
- Not defined: digits are unsupported and take the ERR path. The lookup excludes digit entries.

## Test plan
All cases use UNIT_CYCLES=2.
- Reset: assert `rst` for 3 cycles mid-dash of 'T' → next cycle `morse_signal`=00, `key`=0, `char_done`=0, `char_err`=0, `char_ready`=0; after release `char_ready`=1.
- 'E' (0x45): 01 for 2 cycles, 00 for 6, `char_done` on cycle 8, `char_ready` on cycle 9.
- 'a' (0x61), back-to-back with 'N' (0x4E):
  - 'a': 01×2, 00×2, 10×6, 00×6, `char_done` on cycle 16.
  - 'N': accepted on cycle 17; 10×6, 00×2, 01×2, 00×6.
  - `key` mirrors the marks throughout.
- Space (0x20) after 'E': 8 silent cycles after the handshake, one `char_done`, no marks.
- '#' (0x23): `char_err`=1 for exactly one cycle at T+1, `morse_signal` stays 00, `char_ready` high at T+2.
- '5' (0x35):
  - With `MORSE_ENC_DIGITS_EN`: five dots of 2 cycles separated by 2-cycle gaps, then 6 gap cycles; `char_done` at cycle 24.
  - Without the macro: ERR path as for '#'.

Source files
------------

// File: rtl/morse_encoder.sv
// Morse transmitter: one ASCII character per valid/ready handshake, played out as timed marks and gaps.
// Define MORSE_ENC_DIGITS_EN to add the digits 0-9 to the lookup; otherwise digits take the error path.
module morse_encoder #(
  parameter int UNIT_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       char_valid,
  input  logic [7:0] char_data,
  output logic       char_ready,
  output logic [1:0] morse_signal,
  output logic       key,
  output logic       char_done,
  output logic       char_err
);

  localparam int CW = $clog2(4 * UNIT_CYCLES);
  localparam logic [CW-1:0] DOT_LD  = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] DASH_LD = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] WGAP_LD = CW'(4 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, MARK, GAP, LGAP, WGAP, ERR} state_t;

  typedef struct packed {
    logic       ok;
    logic       space;
    logic [2:0] len;
    logic [4:0] pat;
  } code_t;

  // Patterns are left-aligned: the first element sits in bit 4, 1 = dash.
  function automatic code_t lookup(input logic [7:0] c);
    logic [7:0] u;
    code_t      r;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    r = '{ok: 1'b1, space: 1'b0, len: 3'd0, pat: 5'd0};
    case (u)
      8'h20: r.space = 1'b1;
      8'h41: {r.len, r.pat} = {3'd2, 5'b01000};
      8'h42: {r.len, r.pat} = {3'd4, 5'b10000};
      8'h43: {r.len, r.pat} = {3'd4, 5'b10100};
      8'h44: {r.len, r.pat} = {3'd3, 5'b10000};
      8'h45: {r.len, r.pat} = {3'd1, 5'b00000};
      8'h46: {r.len, r.pat} = {3'd4, 5'b00100};
      8'h47: {r.len, r.pat} = {3'd3, 5'b11000};
      8'h48: {r.len, r.pat} = {3'd4, 5'b00000};
      8'h49: {r.len, r.pat} = {3'd2, 5'b00000};
      8'h4A: {r.len, r.pat} = {3'd4, 5'b01110};
      8'h4B: {r.len, r.pat} = {3'd3, 5'b10100};
      8'h4C: {r.len, r.pat} = {3'd4, 5'b01000};
      8'h4D: {r.len, r.pat} = {3'd2, 5'b11000};
      8'h4E: {r.len, r.pat} = {3'd2, 5'b10000};
      8'h4F: {r.len, r.pat} = {3'd3, 5'b11100};
      8'h50: {r.len, r.pat} = {3'd4, 5'b01100};
      8'h51: {r.len, r.pat} = {3'd4, 5'b11010};
      8'h52: {r.len, r.pat} = {3'd3, 5'b01000};
      8'h53: {r.len, r.pat} = {3'd3, 5'b00000};
      8'h54: {r.len, r.pat} = {3'd1, 5'b10000};
      8'h55: {r.len, r.pat} = {3'd3, 5'b00100};
      8'h56: {r.len, r.pat} = {3'd4, 5'b00010};
      8'h57: {r.len, r.pat} = {3'd3, 5'b01100};
      8'h58: {r.len, r.pat} = {3'd4, 5'b10010};
      8'h59: {r.len, r.pat} = {3'd4, 5'b10110};
      8'h5A: {r.len, r.pat} = {3'd4, 5'b11000};
`ifdef MORSE_ENC_DIGITS_EN
      8'h30: {r.len, r.pat} = {3'd5, 5'b11111};
      8'h31: {r.len, r.pat} = {3'd5, 5'b01111};
      8'h32: {r.len, r.pat} = {3'd5, 5'b00111};
      8'h33: {r.len, r.pat} = {3'd5, 5'b00011};
      8'h34: {r.len, r.pat} = {3'd5, 5'b00001};
      8'h35: {r.len, r.pat} = {3'd5, 5'b00000};
      8'h36: {r.len, r.pat} = {3'd5, 5'b10000};
      8'h37: {r.len, r.pat} = {3'd5, 5'b11000};
      8'h38: {r.len, r.pat} = {3'd5, 5'b11100};
      8'h39: {r.len, r.pat} = {3'd5, 5'b11110};
`endif
      default: r.ok = 1'b0;
    endcase
    return r;
  endfunction

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    idx, idx_n;
  logic [2:0]    len, len_n;
  logic [4:0]    pat, pat_n;
  logic [1:0]    sig_n;
  logic          done_n, err_n, ready_n;
  code_t         code;

  // Next-state logic; outputs are computed from the next state so they can be registered.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    len_n   = len;
    pat_n   = pat;
    code    = lookup(char_data);
    case (state)
      IDLE: begin
        if (char_valid && char_ready) begin
          if (!code.ok) begin
            state_n = ERR;
          end else if (code.space) begin
            state_n = WGAP;
            cnt_n   = WGAP_LD;
          end else begin
            state_n = MARK;
            idx_n   = 3'd0;
            len_n   = code.len;
            pat_n   = code.pat;
            cnt_n   = code.pat[4] ? DASH_LD : DOT_LD;
          end
        end
      end
      MARK: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else if (idx == len - 3'd1) begin
          state_n = LGAP;
          cnt_n   = DASH_LD;
        end else begin
          state_n = GAP;
          cnt_n   = DOT_LD;
          idx_n   = idx + 3'd1;
          pat_n   = {pat[3:0], 1'b0};
        end
      end
      GAP: begin
        if (cnt != '0) begin
          cnt_n = cnt - CW'(1);
        end else begin
          state_n = MARK;
          cnt_n   = pat[4] ? DASH_LD : DOT_LD;
        end
      end
      LGAP, WGAP: begin
        if (cnt != '0) cnt_n = cnt - CW'(1);
        else state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    sig_n   = (state_n == MARK) ? (pat_n[4] ? 2'b10 : 2'b01) : 2'b00;
    done_n  = (state_n == LGAP || state_n == WGAP) && (cnt_n == '0);
    err_n   = (state_n == ERR);
    ready_n = (state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      idx          <= 3'd0;
      len          <= 3'd0;
      pat          <= 5'd0;
      morse_signal <= 2'b00;
      key          <= 1'b0;
      char_done    <= 1'b0;
      char_err     <= 1'b0;
      char_ready   <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      idx          <= idx_n;
      len          <= len_n;
      pat          <= pat_n;
      morse_signal <= sig_n;
      key          <= |sig_n;
      char_done    <= done_n;
      char_err     <= err_n;
      char_ready   <= ready_n;
    end
  end

endmodule

// File: tb/tb_morse_encoder.sv
// Directed bench for morse_encoder at UNIT_CYCLES=2: a table of characters with hand-entered codes,
// expanded into per-cycle expectations, plus a mid-character reset sequence.
module tb_morse_encoder;

  localparam int U = 2;
  localparam logic [1:0] K_LETTER = 2'd0;
  localparam logic [1:0] K_SPACE  = 2'd1;
  localparam logic [1:0] K_ERR    = 2'd2;

  typedef struct packed {
    logic [7:0] ch;
    logic [1:0] kind;
    logic       chain;
    logic [2:0] len;
    logic [4:0] pat;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       char_valid;
  logic [7:0] char_data;
  logic       char_ready;
  logic [1:0] morse_signal;
  logic       key;
  logic       char_done;
  logic       char_err;

  int vecCount  = 0;
  int missCount = 0;

  vec_t vecs[14];

  always #5 clk = ~clk;

  morse_encoder #(.UNIT_CYCLES(U)) dut (
    .clk(clk),
    .rst(rst),
    .char_valid(char_valid),
    .char_data(char_data),
    .char_ready(char_ready),
    .morse_signal(morse_signal),
    .key(key),
    .char_done(char_done),
    .char_err(char_err)
  );

  function automatic vec_t mk(input logic [7:0] ch, input logic [1:0] kind, input logic chain,
                              input logic [2:0] len, input logic [4:0] pat);
    vec_t v;
    v.ch = ch; v.kind = kind; v.chain = chain; v.len = len; v.pat = pat;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] sig, input logic k,
                             input logic d, input logic e, input logic r);
    vecCount++;
    if (morse_signal !== sig || key !== k || char_done !== d || char_err !== e || char_ready !== r) begin
      missCount++;
      $display("[TB] FAIL %s @%0t: got sig=%b key=%b done=%b err=%b ready=%b, want sig=%b key=%b done=%b err=%b ready=%b",
               name, $time, morse_signal, key, char_done, char_err, char_ready, sig, k, d, e, r);
    end
  endtask

  // Entered on an idle cycle; returns on the cycle where char_ready should be back.
  task automatic applyStimulus(input vec_t v, input logic [7:0] nextCh);
    logic [1:0] ms;
    int n;
    checkOutput("idle_ready", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    char_valid = 1'b1;
    char_data  = v.ch;
    step();
    if (v.chain) char_data = nextCh;
    else char_valid = 1'b0;
    case (v.kind)
      K_ERR: begin
        checkOutput("err_pulse", 2'b00, 1'b0, 1'b0, 1'b1, 1'b0);
        step();
      end
      K_SPACE: begin
        for (int i = 0; i < 4 * U; i++) begin
          checkOutput("word_gap", 2'b00, 1'b0, (i == 4 * U - 1), 1'b0, 1'b0);
          step();
        end
      end
      default: begin
        for (int e = 0; e < int'(v.len); e++) begin
          ms = v.pat[4 - e] ? 2'b10 : 2'b01;
          n  = v.pat[4 - e] ? 3 * U : U;
          for (int c = 0; c < n; c++) begin
            checkOutput("mark", ms, 1'b1, 1'b0, 1'b0, 1'b0);
            step();
          end
          if (e < int'(v.len) - 1) begin
            for (int c = 0; c < U; c++) begin
              checkOutput("elem_gap", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
              step();
            end
          end
        end
        for (int c = 0; c < 3 * U; c++) begin
          checkOutput("letter_gap", 2'b00, 1'b0, (c == 3 * U - 1), 1'b0, 1'b0);
          step();
        end
      end
    endcase
    if (!v.chain) begin
      checkOutput("ready_back", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
      step();
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: got no finish, want finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    vecs[0]  = mk(8'h45, K_LETTER, 1'b1, 3'd1, 5'b00000);  // E, then space held on valid
    vecs[1]  = mk(8'h20, K_SPACE,  1'b0, 3'd0, 5'b00000);
    vecs[2]  = mk(8'h61, K_LETTER, 1'b1, 3'd2, 5'b01000);  // a, then N back-to-back
    vecs[3]  = mk(8'h4E, K_LETTER, 1'b0, 3'd2, 5'b10000);
    vecs[4]  = mk(8'h23, K_ERR,    1'b0, 3'd0, 5'b00000);
`ifdef MORSE_ENC_DIGITS_EN
    vecs[5]  = mk(8'h35, K_LETTER, 1'b0, 3'd5, 5'b00000);
    vecs[13] = mk(8'h30, K_LETTER, 1'b0, 3'd5, 5'b11111);
`else
    vecs[5]  = mk(8'h35, K_ERR,    1'b0, 3'd0, 5'b00000);
    vecs[13] = mk(8'h30, K_ERR,    1'b0, 3'd0, 5'b00000);
`endif
    vecs[6]  = mk(8'h60, K_ERR,    1'b0, 3'd0, 5'b00000);
    vecs[7]  = mk(8'h7B, K_ERR,    1'b1, 3'd0, 5'b00000);
    vecs[8]  = mk(8'h40, K_ERR,    1'b0, 3'd0, 5'b00000);
    vecs[9]  = mk(8'h5B, K_ERR,    1'b0, 3'd0, 5'b00000);
    vecs[10] = mk(8'h51, K_LETTER, 1'b0, 3'd4, 5'b11010);
    vecs[11] = mk(8'h7A, K_LETTER, 1'b0, 3'd4, 5'b11000);
    vecs[12] = mk(8'h3A, K_ERR,    1'b0, 3'd0, 5'b00000);

    rst        = 1'b1;
    char_valid = 1'b0;
    char_data  = 8'h00;
    step();
    checkOutput("reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("reset_hold", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 14; i++)
      applyStimulus(vecs[i], (i < 13) ? vecs[i + 1].ch : 8'h00);

    // Reset in the middle of the dash of 'T'.
    checkOutput("t_idle", 2'b00, 1'b0, 1'b0, 1'b0, 1'b1);
    char_valid = 1'b1;
    char_data  = 8'h54;
    step();
    char_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      checkOutput("t_dash", 2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
      step();
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("mid_reset", 2'b00, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
    step();
    applyStimulus(mk(8'h45, K_LETTER, 1'b0, 3'd1, 5'b00000), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
